// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types, constants and priority-rank helper for the PIC sequencer
package pic_pkg;

    localparam int         NUM_IR       = 8;
    localparam logic [2:0] SPURIOUS_LVL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK1  = 2'd1,
        ST_WAIT2 = 2'd2,
        ST_ACK2  = 2'd3
    } pic_state_e;

    // Rank 0 is the highest priority: the level just after the current lowest.
    function automatic logic [2:0] rank(input logic [2:0] level, input logic [2:0] lowest);
        return level - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// rtl/pic_prio_resolver.sv - rotating priority scan over an 8-bit request vector
module pic_prio_resolver
    import pic_pkg::*;
(
    input  logic [7:0] vec,
    input  logic [2:0] lowest,
    output logic       valid,
    output logic [2:0] level,
    output logic [2:0] rank
);

    // Scan from the lowest rank upward so the last hit is the highest priority.
    always_comb begin
        valid = 1'b0;
        level = SPURIOUS_LVL;
        rank  = 3'd7;
        for (int k = NUM_IR - 1; k >= 0; k--) begin
            if (vec[lowest + 3'(k) + 3'd1]) begin
                valid = 1'b1;
                level = lowest + 3'(k) + 3'd1;
                rank  = pic_pkg::rank(lowest + 3'(k) + 3'd1, lowest);
            end
        end
    end

endmodule

// File: rtl/pic_int_sequencer.sv
// rtl/pic_int_sequencer.sv - IRR/ISR ownership, priority, INT and 8086-mode INTA vector sequencing
module pic_int_sequencer
    import pic_pkg::*;
#(
    parameter int VEC_BASE_W = 5
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            ir,
    input  logic [7:0]            imr,
    input  logic                  ltim,
    input  logic                  aeoi,
    input  logic                  rot_aeoi,
    input  logic [VEC_BASE_W-1:0] vec_base,
    input  logic                  ninta,
    input  logic                  eoi_req,
    input  logic                  eoi_sl,
    input  logic                  eoi_rot,
    input  logic [2:0]            eoi_lvl,
    output logic                  int_o,
    output logic [7:0]            irr,
    output logic [7:0]            isr,
    output logic [7:0]            dout,
    output logic                  dout_oe
);

    pic_state_e state;
    logic [7:0] ir_q;
    logic       ninta_q;
    logic [2:0] lowest;
    logic [2:0] win;
    logic       win_spur;

    logic       req_valid, isr_valid;
    logic [2:0] req_level, isr_level;
    logic [2:0] req_rank, isr_rank;

    pic_prio_resolver u_req_res (
        .vec    (irr & ~imr),
        .lowest (lowest),
        .valid  (req_valid),
        .level  (req_level),
        .rank   (req_rank)
    );

    pic_prio_resolver u_isr_res (
        .vec    (isr),
        .lowest (lowest),
        .valid  (isr_valid),
        .level  (isr_level),
        .rank   (isr_rank)
    );

    logic       ninta_fall;
    logic       ack1;
    logic       ack2_done;
    logic [7:0] ack_mask;
    logic [7:0] eoi_mask;
    logic [7:0] aeoi_mask;
    logic       eoi_hit;
    logic [2:0] eoi_level;
    logic [7:0] irr_next;
    logic [7:0] isr_next;
    logic       int_next;

    always_comb begin
        ninta_fall = ninta_q & ~ninta;
        ack1       = (state == ST_IDLE) && ninta_fall;
        ack2_done  = (state == ST_ACK2) && ninta;
        ack_mask   = (ack1 && req_valid) ? (8'b1 << req_level) : 8'h00;

        eoi_level = eoi_sl ? eoi_lvl : isr_level;
        eoi_hit   = eoi_req && (eoi_sl || isr_valid);
        eoi_mask  = eoi_hit ? (8'b1 << eoi_level) : 8'h00;

        aeoi_mask = (ack2_done && aeoi && !win_spur) ? (8'b1 << win) : 8'h00;

        // An edge coinciding with its own acknowledge is deliberately dropped.
        if (ltim) begin
            irr_next = ir & ~ack_mask;
        end else begin
            irr_next = (irr | (ir & ~ir_q)) & ir & ~ack_mask;
        end

        isr_next = (isr & ~eoi_mask & ~aeoi_mask) | ack_mask;

        if (state == ST_ACK1) begin
            int_next = int_o;
        end else begin
            int_next = req_valid && (!isr_valid || (req_rank < isr_rank));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ir_q     <= 8'h00;
            ninta_q  <= 1'b1;
            irr      <= 8'h00;
            isr      <= 8'h00;
            int_o    <= 1'b0;
            dout     <= 8'h00;
            dout_oe  <= 1'b0;
            lowest   <= 3'd7;
            win      <= SPURIOUS_LVL;
            win_spur <= 1'b0;
        end else begin
            ir_q    <= ir;
            ninta_q <= ninta;
            irr     <= irr_next;
            isr     <= isr_next;
            int_o   <= int_next;

            if (eoi_hit && eoi_rot) begin
                lowest <= eoi_level;
            end else if (ack2_done && aeoi && rot_aeoi && !win_spur) begin
                lowest <= win;
            end

            case (state)
                ST_IDLE: begin
                    if (ninta_fall) begin
                        state    <= ST_ACK1;
                        win      <= req_valid ? req_level : SPURIOUS_LVL;
                        win_spur <= !req_valid;
                    end
                end
                ST_ACK1: begin
                    if (ninta) begin
                        state <= ST_WAIT2;
                    end
                end
                ST_WAIT2: begin
                    if (ninta_fall) begin
                        state   <= ST_ACK2;
                        dout    <= 8'({vec_base, win});
                        dout_oe <= 1'b1;
                    end
                end
                ST_ACK2: begin
                    if (ninta) begin
                        state   <= ST_IDLE;
                        dout_oe <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pic_int_sequencer.md
# pic_int_sequencer

Interrupt priority and acknowledge sequencer for the 8259A-compatible PIC core. It owns the IRR/ISR state, resolves priority across IR0–IR7 with optional rotation, and raises INT. It runs the two-pulse 8086-mode INTA handshake and drives the interrupt vector onto the internal data bus. The register-file/command decoder configures it and forwards EOI commands to it.

## Interface
- `VEC_BASE_W`, default 5: width of the vector base field (T7–T3).
- `clk` in 1: single system clock; every register is updated on its rising edge.
- `reset` in 1: synchronous, active-high. Clears all state.
- `ir` in 8: raw interrupt request lines, already synchronized to `clk`.
- `imr` in 8: interrupt mask; 1 = masked.
- `ltim` in 1: 1 = level-triggered, 0 = edge-triggered.
- `aeoi` in 1: auto-EOI enable.
- `rot_aeoi` in 1: rotate priority on auto-EOI.
- `vec_base` in 5: vector bits [7:3].
- `ninta` in 1: interrupt acknowledge, active low, synchronized.
- `eoi_req` in 1: one-cycle EOI command strobe.
- `eoi_sl` in 1: 1 = specific EOI, 0 = non-specific.
- `eoi_rot` in 1: rotate priority on this EOI.
- `eoi_lvl` in 3: level targeted by a specific EOI.
- `int_o` out 1: interrupt request to the CPU.
- `irr` out 8, `isr` out 8: request and in-service registers, exposed for status reads.
- `dout` out 8, `dout_oe` out 1: vector byte and its bus enable.

## Operation
- Reset values:
  - `irr`, `isr`, `int_o`, `dout`, `dout_oe` = 0.
  - FSM = IDLE.
  - `lowest` (lowest-priority level) = 7, so IR0 has the highest priority.
- IRR update:
  - Edge mode: a bit is set when its `ir` bit is 1 and was 0 on the previous sample. It is cleared when `ir` drops to 0 or when the level is acknowledged.
  - Level mode: `irr[i]` = `ir[i]`, except for the cycle in which the level is acknowledged.
- Priority:
  - Scan starts at level `lowest+1` mod 8 and wraps around.
  - The candidate is the first level with `irr & ~imr` set.
  - `int_o` = 1 when a candidate exists and its rank is above the highest-ranked `isr` bit (fully nested mode).
- FSM states: IDLE, ACK1, WAIT2, ACK2.
  - IDLE → ACK1 on a `ninta` falling edge (sampled 1 then 0).
    - Latch the candidate as `win`, set `isr[win]`, clear `irr[win]`.
    - If there is no candidate, `win` = 7 (spurious) and `isr` is unchanged.
    - Nothing is driven in this state.
  - ACK1 → WAIT2 on `ninta` = 1.
  - WAIT2 → ACK2 on a `ninta` falling edge.
    - `dout` = {`vec_base`, `win`}, `dout_oe` = 1 while `ninta` = 0.
  - ACK2 → IDLE on `ninta` = 1.
    - `dout_oe` falls in the same cycle.
    - If `aeoi` is set and the acknowledge was not spurious, clear `isr[win]`.
    - If `rot_aeoi` is also set, `lowest` = `win`.
- EOI (on `eoi_req`):
  - Non-specific: clears the highest-ranked `isr` bit. No effect if `isr` = 0.
  - Specific: clears `isr[eoi_lvl]`.
  - If `eoi_rot` is set, `lowest` takes the cleared level. A non-specific EOI with `isr` = 0 does not rotate.
- Simultaneous events:
  - EOI clear is applied before the ACK1 set, so a set of the same bit wins.
  - An IR edge in the same cycle as its acknowledge is lost.
- `imr` changes take effect on the next priority evaluation. A masked level already in ISR is unaffected.
- Reset mid-handshake returns to IDLE with `dout_oe` = 0 in the next cycle.

## Timing
- `irr` updates 1 cycle after an `ir` change.
- `int_o` is registered and updates 1 cycle after `irr`/`isr`/`imr` change, so an `ir` edge reaches `int_o` in 2 cycles.
- A `ninta` edge is detected in the cycle after it appears at the input.
- ISR set and `dout`/`dout_oe` become valid 1 cycle after the detected edge and hold until `ninta` is sampled high.
- EOI takes effect 1 cycle after `eoi_req`.
- `int_o` stays asserted through ACK1 and is re-evaluated afterwards.

## Structure
- Package `pic_pkg`:
  - FSM state enum.
  - Constants `NUM_IR` = 8 and `SPURIOUS_LVL` = 7.
  - Function `rank(level, lowest)` returning the 3-bit priority rank.
- Sub-module `pic_prio_resolver`: combinational rotating scan of an 8-bit vector given `lowest`. Outputs `valid`, `level`, `rank`. It is instantiated twice, once for `irr & ~imr` and once for `isr`.

## Test plan
- Reset, then pulse `ir[3]` (edge mode, `imr` = 0) → `int_o` = 1 two cycles later. An INTA pair gives `isr` = 08h, `irr` = 0, and `dout` = {`vec_base`=5'h04, 3} = 23h on the second pulse.
- `ir` = 0x24 pending, with `isr[2]` already set → `int_o` = 0. A non-specific EOI clears `isr[2]`, then `int_o` = 1 and the next acknowledge selects IR2.
- Rotation: specific EOI with `eoi_rot`, `eoi_lvl` = 4 → `lowest` = 4. With `ir` = 0x21 pending, IR5 wins over IR0.
- Spurious: `ir[6]` is raised, then dropped before ACK1 → `dout` = {base, 7}, `isr` unchanged.
- `aeoi` = 1, `rot_aeoi` = 1, acknowledge of IR1 → `isr` = 0 after the second pulse and `lowest` = 1.
- `reset` asserted during WAIT2 → next cycle: FSM IDLE, `dout_oe` = 0, `isr` = 0, `int_o` = 0.
